// File: rtl/counter_xn_if.sv
// Register-window bus into counter_xn: a one-cycle write strobe with channel/register
// select, plus a combinational read-back of the selected channel's count.
interface counter_xn_if #(
    parameter int CW  = 32,
    parameter int CHW = 2
);
    logic           counter_we;
    logic [CHW-1:0] counter_ch;
    logic [1:0]     reg_sel;
    logic [CW-1:0]  counter_val;
    logic [CW-1:0]  counter_out;

    modport master (
        output counter_we, counter_ch, reg_sel, counter_val,
        input  counter_out
    );

    modport slave (
        input  counter_we, counter_ch, reg_sel, counter_val,
        output counter_out
    );
endinterface

// File: rtl/counter_xn.sv
// NCH independent programmable down-counters (one-shot, periodic, PWM, square) with
// edge-detected count-rate inputs, sticky per-channel flags and a merged interrupt.
module counter_xn #(
    parameter int NCH = 3,
    parameter int CW  = 32,
    parameter int CHW = 2
) (
    input  logic             clk,
    input  logic             RSTN,
    input  logic [NCH-1:0]   tick_src,
    counter_xn_if.slave      bus,
    output logic [NCH-1:0]   ch_out,
    output logic [NCH-1:0]   irq_flag,
    output logic             irq
);

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'b00,
        MODE_PERIODIC = 2'b01,
        MODE_PWM      = 2'b10,
        MODE_SQUARE   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        REG_COUNT   = 2'b00,
        REG_COMPARE = 2'b01,
        REG_CONTROL = 2'b10,
        REG_IRQCLR  = 2'b11
    } reg_e;

    typedef struct packed {
        logic  irq_en;
        logic  enable;
        mode_e mode;
    } ctrl_t;

    reg_e           sel;
    logic [CW-1:0]  count_all [NCH];
    logic [NCH-1:0] irq_en;

    assign sel = reg_e'(bus.reg_sel);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CW-1:0] count_q, reload_q, compare_q, count_nxt;
        ctrl_t         ctrl_q;
        logic          tick_d_q, out_q, flag_q;
        logic          out_nxt, flag_nxt;
        logic          tick, wr, load, step, evt;

        assign tick = tick_src[g] & ~tick_d_q;
        assign wr   = bus.counter_we && (bus.counter_ch == CHW'(g));
        // A reload write in the same cycle as a tick swallows the tick.
        assign load = wr && (sel == REG_COUNT);
        assign step = ctrl_q.enable && tick && !load;
        assign evt  = step && (count_q == CW'(1));

        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        always_comb begin
            count_nxt = count_q;
            if (load)
                count_nxt = bus.counter_val;
            else if (evt)
                count_nxt = (ctrl_q.mode == MODE_ONESHOT) ? '0 : reload_q;
            else if (step && (count_q > CW'(1)))
                count_nxt = count_q - CW'(1);
        end

        always_comb begin
            out_nxt = out_q;
            unique case (ctrl_q.mode)
                MODE_ONESHOT:  if (evt) out_nxt = 1'b1;
                MODE_PERIODIC: out_nxt = evt;
                MODE_PWM:      out_nxt = ctrl_q.enable && (count_nxt < compare_q);
                MODE_SQUARE:   if (evt) out_nxt = ~out_q;
            endcase
            if (load || (wr && (sel == REG_CONTROL)))
                out_nxt = 1'b0;
        end

        // Setting beats clearing when both land in the same cycle.
        assign flag_nxt = evt ||
                          (flag_q && !(wr && (sel == REG_IRQCLR) && bus.counter_val[0]));

        // NOTE: all state updates are non-blocking so every register sees pre-edge values.
        always_ff @(posedge clk) begin
            if (!RSTN) begin
                count_q   <= '0;
                reload_q  <= '0;
                compare_q <= '0;
                ctrl_q    <= '0;
                tick_d_q  <= 1'b0;
                out_q     <= 1'b0;
                flag_q    <= 1'b0;
            end else begin
                tick_d_q <= tick_src[g];
                count_q  <= count_nxt;
                out_q    <= out_nxt;
                flag_q   <= flag_nxt;
                if (load)
                    reload_q <= bus.counter_val;
                if (wr && (sel == REG_COMPARE))
                    compare_q <= bus.counter_val;
                if (wr && (sel == REG_CONTROL))
                    ctrl_q <= ctrl_t'(bus.counter_val[3:0]);
            end
        end

        assign count_all[g] = count_q;
        assign ch_out[g]    = out_q;
        assign irq_flag[g]  = flag_q;
        assign irq_en[g]    = ctrl_q.irq_en;
    end

    // Unpopulated channel numbers read back as zero.
    always_comb begin
        bus.counter_out = '0;
        for (int i = 0; i < NCH; i++)
            if (bus.counter_ch == CHW'(i))
                bus.counter_out = count_all[i];
    end

    assign irq = |(irq_flag & irq_en);

endmodule

// File: tb/tb_counter_xn.sv
// Self-checking bench for counter_xn: directed scenarios plus randomized traffic, all
// compared against a behavioural per-channel model kept in the bench.
module tb_counter_xn;

    localparam int NCH = 3;
    localparam int CW  = 32;
    localparam int CHW = 2;
    localparam int VW  = NCH * CW + 2 * NCH + 1;

    logic           clk = 1'b0;
    logic           RSTN;
    logic [NCH-1:0] tick_src;
    logic [NCH-1:0] ch_out, irq_flag;
    logic           irq;

    counter_xn_if #(.CW(CW), .CHW(CHW)) bus ();

    counter_xn #(.NCH(NCH), .CW(CW), .CHW(CHW)) dut (
        .clk      (clk),
        .RSTN     (RSTN),
        .tick_src (tick_src),
        .bus      (bus),
        .ch_out   (ch_out),
        .irq_flag (irq_flag),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [CW-1:0]  m_count [NCH];
    logic [CW-1:0]  m_reload [NCH];
    logic [CW-1:0]  m_compare [NCH];
    logic [3:0]     m_ctrl [NCH];
    logic [NCH-1:0] m_out, m_flag, m_prev_src;

    // One clock edge of the model, applied to the inputs currently on the pins.
    function automatic void model_edge();
        logic [NCH-1:0] rises;
        logic           hit, ev, en;
        logic [1:0]     mode;
        logic [CW-1:0]  nc;
        logic           no;
        if (!RSTN) begin
            for (int i = 0; i < NCH; i++) begin
                m_count[i] = '0; m_reload[i] = '0; m_compare[i] = '0; m_ctrl[i] = '0;
            end
            m_out = '0; m_flag = '0; m_prev_src = '0;
            return;
        end
        rises      = tick_src & ~m_prev_src;
        m_prev_src = tick_src;
        for (int i = 0; i < NCH; i++) begin
            hit  = bus.counter_we && (int'(bus.counter_ch) == i);
            en   = m_ctrl[i][2];
            mode = m_ctrl[i][1:0];
            ev   = 1'b0;
            nc   = m_count[i];
            no   = m_out[i];
            if (hit && bus.reg_sel == 2'd0) begin
                nc          = bus.counter_val;
                no          = 1'b0;
                m_reload[i] = bus.counter_val;
            end else begin
                if (en && rises[i] && m_count[i] != 0) begin
                    if (m_count[i] == 1) begin
                        ev = 1'b1;
                        nc = (mode == 2'd0) ? '0 : m_reload[i];
                    end else begin
                        nc = m_count[i] - 1;
                    end
                end
                case (mode)
                    2'd0: if (ev) no = 1'b1;
                    2'd1: no = ev;
                    2'd2: no = en && (nc < m_compare[i]);
                    default: if (ev) no = ~no;
                endcase
                if (hit && bus.reg_sel == 2'd2) begin
                    no        = 1'b0;
                    m_ctrl[i] = bus.counter_val[3:0];
                end
                if (hit && bus.reg_sel == 2'd1) m_compare[i] = bus.counter_val;
                if (hit && bus.reg_sel == 2'd3 && bus.counter_val[0]) m_flag[i] = 1'b0;
            end
            if (ev) m_flag[i] = 1'b1;
            m_count[i] = nc;
            m_out[i]   = no;
        end
    endfunction

    function automatic logic [VW-1:0] model_vec();
        logic [NCH*CW-1:0] c;
        logic [NCH-1:0]    en;
        for (int i = 0; i < NCH; i++) begin
            c[i*CW +: CW] = m_count[i];
            en[i]         = m_ctrl[i][3];
        end
        return {m_out, m_flag, |(m_flag & en), c};
    endfunction

    task automatic sample_vec(output logic [VW-1:0] v);
        logic [NCH*CW-1:0] c;
        for (int i = 0; i < NCH; i++) begin
            bus.counter_ch = CHW'(i);
            #1;
            c[i*CW +: CW] = bus.counter_out;
        end
        v = {ch_out, irq_flag, irq, c};
    endtask

    task automatic read_count(input int ch, output logic [CW-1:0] v);
        bus.counter_ch = CHW'(ch);
        #1;
        v = bus.counter_out;
    endtask

    task automatic drive(input logic we, input int ch, input logic [1:0] sel,
                         input logic [CW-1:0] val, input logic [NCH-1:0] ts);
        bus.counter_we  = we;
        bus.counter_ch  = CHW'(ch);
        bus.reg_sel     = sel;
        bus.counter_val = val;
        tick_src        = ts;
        @(posedge clk);
        model_edge();
        #1;
        bus.counter_we = 1'b0;
    endtask

    task automatic wr(input int ch, input logic [1:0] sel, input logic [CW-1:0] val);
        drive(1'b1, ch, sel, val, tick_src);
    endtask

    task automatic tick_cycle(input int i, input logic v);
        logic [NCH-1:0] ts;
        ts    = tick_src;
        ts[i] = v;
        drive(1'b0, 0, 2'd0, '0, ts);
    endtask

    task automatic test_reset();
        logic [VW-1:0] dv;
        RSTN = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 0, 2'd0, '0, (k == 0) ? '1 : '0);
            sample_vec(dv);
            checks++;
            if (dv !== '0) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got=%h want=0", k, dv);
            end
        end
        RSTN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 0, 2'd0, '0, k[0] ? '0 : '1);
            checks++;
            if ({ch_out, irq_flag, irq} !== '0) begin
                errors++;
                $display("FAIL reset_no_event cyc=%0d got=%b want=0", k, {ch_out, irq_flag, irq});
            end
        end
        tick_cycle(0, 1'b0);
    endtask

    task automatic test_one_shot();
        logic [CW-1:0] c;
        logic [VW-1:0] dv, mv;
        tick_src = '0;
        wr(0, 2'd0, 32'd3);
        read_count(0, c);
        checks++;
        if (c !== 32'd3) begin errors++; $display("FAIL oneshot_load got=%0d want=3", c); end
        wr(0, 2'd2, 32'hC);
        for (int k = 0; k < 3; k++) begin
            tick_cycle(0, 1'b1);
            read_count(0, c);
            checks++;
            if (c !== CW'(2 - k)) begin
                errors++;
                $display("FAIL oneshot_count edge=%0d got=%0d want=%0d", k, c, 2 - k);
            end
            tick_cycle(0, 1'b0);
        end
        checks++;
        if ({ch_out[0], irq_flag[0], irq} !== 3'b111) begin
            errors++;
            $display("FAIL oneshot_event got=%b want=111", {ch_out[0], irq_flag[0], irq});
        end
        tick_cycle(0, 1'b1);
        tick_cycle(0, 1'b0);
        read_count(0, c);
        checks++;
        if (c !== '0 || ch_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL oneshot_hold count=%0d out=%b want 0/1", c, ch_out[0]);
        end
        wr(0, 2'd3, 32'd1);
        checks++;
        if (irq !== 1'b0 || irq_flag[0] !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_clear irq=%b flag=%b want 0/0", irq, irq_flag[0]);
        end
        sample_vec(dv); mv = model_vec();
        checks++;
        if (dv !== mv) begin errors++; $display("FAIL oneshot_model got=%h want=%h", dv, mv); end
    endtask

    task automatic test_periodic();
        logic [CW-1:0] c;
        wr(1, 2'd0, 32'd2);
        wr(1, 2'd2, 32'h5);
        for (int k = 0; k < 4; k++) begin
            tick_cycle(1, 1'b1);
            read_count(1, c);
            checks++;
            if (c !== (k[0] ? 32'd2 : 32'd1) || ch_out[1] !== k[0]) begin
                errors++;
                $display("FAIL periodic_edge edge=%0d count=%0d out=%b want %0d/%b",
                         k, c, ch_out[1], k[0] ? 2 : 1, k[0]);
            end
            tick_cycle(1, 1'b0);
            checks++;
            if (ch_out[1] !== 1'b0) begin
                errors++;
                $display("FAIL periodic_pulse_width edge=%0d got=%b want=0", k, ch_out[1]);
            end
        end
        checks++;
        if (irq_flag[1] !== 1'b1 || irq !== 1'b0) begin
            errors++;
            $display("FAIL periodic_irq flag=%b irq=%b want 1/0", irq_flag[1], irq);
        end
    endtask

    task automatic test_pwm();
        int high;
        logic [VW-1:0] dv, mv;
        wr(2, 2'd0, 32'd4);
        wr(2, 2'd1, 32'd3);
        wr(2, 2'd2, 32'h6);
        high = 0;
        for (int k = 0; k < 8; k++) begin
            tick_cycle(2, 1'b1); high += int'(ch_out[2]);
            tick_cycle(2, 1'b0); high += int'(ch_out[2]);
            sample_vec(dv); mv = model_vec();
            checks++;
            if (dv !== mv) begin
                errors++;
                $display("FAIL pwm_model edge=%0d got=%h want=%h", k, dv, mv);
            end
        end
        checks++;
        if (high != 8) begin errors++; $display("FAIL pwm_duty got=%0d want=8", high); end
        wr(2, 2'd1, 32'd0);
        high = 0;
        for (int k = 0; k < 8; k++) begin
            tick_cycle(2, 1'b1); high += int'(ch_out[2]);
            tick_cycle(2, 1'b0); high += int'(ch_out[2]);
        end
        checks++;
        if (high != 0) begin errors++; $display("FAIL pwm_cmp0 got=%0d want=0", high); end
        wr(2, 2'd1, 32'd5);
        tick_cycle(2, 1'b0);
        high = 0;
        for (int k = 0; k < 8; k++) begin
            tick_cycle(2, 1'b1); high += int'(ch_out[2]);
            tick_cycle(2, 1'b0); high += int'(ch_out[2]);
        end
        checks++;
        if (high != 16) begin errors++; $display("FAIL pwm_cmp_gt_reload got=%0d want=16", high); end
    endtask

    task automatic test_square_collision();
        logic [CW-1:0]  c;
        logic [NCH-1:0] ts;
        wr(0, 2'd2, 32'hF);
        wr(0, 2'd0, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick_cycle(0, 1'b1);
            checks++;
            if (ch_out[0] !== ~k[0]) begin
                errors++;
                $display("FAIL square_toggle edge=%0d got=%b want=%b", k, ch_out[0], ~k[0]);
            end
            tick_cycle(0, 1'b0);
        end
        ts = tick_src; ts[0] = 1'b1;
        drive(1'b1, 0, 2'd0, 32'd5, ts);
        read_count(0, c);
        checks++;
        if (c !== 32'd5 || ch_out[0] !== 1'b0) begin
            errors++;
            $display("FAIL write_beats_tick count=%0d out=%b want 5/0", c, ch_out[0]);
        end
        tick_cycle(0, 1'b0);
        wr(0, 2'd0, 32'd1);
        wr(0, 2'd3, 32'd1);
        checks++;
        if (irq_flag[0] !== 1'b0) begin
            errors++;
            $display("FAIL square_clear got=%b want=0", irq_flag[0]);
        end
        ts = tick_src; ts[0] = 1'b1;
        drive(1'b1, 0, 2'd3, 32'd1, ts);
        checks++;
        if (irq_flag[0] !== 1'b1 || ch_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL set_beats_clear flag=%b out=%b want 1/1", irq_flag[0], ch_out[0]);
        end
        tick_cycle(0, 1'b0);
    endtask

    task automatic test_bounds();
        logic [CW-1:0] c;
        logic [VW-1:0] dv, mv;
        wr(3, 2'd0, 32'd7);
        wr(3, 2'd2, 32'hF);
        read_count(3, c);
        checks++;
        if (c !== '0) begin errors++; $display("FAIL bounds_read got=%0d want=0", c); end
        sample_vec(dv); mv = model_vec();
        checks++;
        if (dv !== mv) begin errors++; $display("FAIL bounds_isolation got=%h want=%h", dv, mv); end
        wr(1, 2'd0, 32'd10);
        wr(1, 2'd2, 32'h5);
        for (int k = 0; k < 3; k++) begin tick_cycle(1, 1'b1); tick_cycle(1, 1'b0); end
        wr(1, 2'd2, 32'h1);
        for (int k = 0; k < 3; k++) begin tick_cycle(1, 1'b1); tick_cycle(1, 1'b0); end
        read_count(1, c);
        checks++;
        if (c !== 32'd7) begin errors++; $display("FAIL disable_freeze got=%0d want=7", c); end
        wr(1, 2'd2, 32'h5);
        tick_cycle(1, 1'b1);
        tick_cycle(1, 1'b0);
        read_count(1, c);
        checks++;
        if (c !== 32'd6) begin errors++; $display("FAIL disable_resume got=%0d want=6", c); end
    endtask

    task automatic test_random();
        logic [VW-1:0]  dv, mv;
        logic [1:0]     sel;
        logic [CW-1:0]  val;
        for (int k = 0; k < 600; k++) begin
            RSTN = ($urandom_range(0, 199) != 0);
            sel  = 2'($urandom_range(0, 3));
            val  = (sel == 2'd2) ? CW'($urandom) : CW'($urandom_range(0, 6));
            drive(($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), sel, val,
                  NCH'($urandom));
            sample_vec(dv); mv = model_vec();
            checks++;
            if (dv !== mv) begin
                errors++;
                $display("FAIL random_model cyc=%0d got=%h want=%h", k, dv, mv);
            end
        end
        RSTN = 1'b1;
    endtask

    initial begin
        RSTN            = 1'b0;
        tick_src        = '0;
        bus.counter_we  = 1'b0;
        bus.counter_ch  = '0;
        bus.reg_sel     = '0;
        bus.counter_val = '0;
        test_reset();
        test_one_shot();
        test_periodic();
        test_pwm();
        test_square_collision();
        test_bounds();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
